// File: rtl/fir_coef_loader_pkg.sv
// rtl/fir_coef_loader_pkg.sv - shared constants for the FIR coefficient loader
// Purpose: FSM state encodings, error codes and default bus widths shared by
//          the loader, its bus interface and the bench.
package fir_coef_loader_pkg;

  localparam int COEF_W_DEF = 18;
  localparam int ADDR_W_DEF = 32;

  // State encodings kept as plain 2-bit constants so the state register can
  // be probed and compared like any other vector.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_NONE  = 2'd0;
  localparam err_code_t ERR_TILE  = 2'd1;
  localparam err_code_t ERR_COUNT = 2'd2;
  localparam err_code_t ERR_ABORT = 2'd3;

endpackage

// File: rtl/fir_coef_loader_if.sv
// rtl/fir_coef_loader_if.sv - command and coefficient stream bus into the loader
// Purpose: groups the load-command handshake and the coefficient stream.
// Signals:
//   cmd_tvalid/cmd_tready   load command handshake
//   cmd_tile/base/count     target tile, first address, number of taps
//   coef_tvalid/coef_tready coefficient stream handshake
//   coef_tdata              coefficient value
// Modports: master = host side, slave = loader side.
interface fir_coef_loader_if
  import fir_coef_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter int CNT_W  = 9
);

  logic              cmd_tvalid;
  logic              cmd_tready;
  logic [7:0]        cmd_tile;
  logic [ADDR_W-1:0] cmd_base;
  logic [CNT_W-1:0]  cmd_count;
  logic              coef_tvalid;
  logic              coef_tready;
  logic [COEF_W-1:0] coef_tdata;

  modport master (
    output cmd_tvalid, cmd_tile, cmd_base, cmd_count, coef_tvalid, coef_tdata,
    input  cmd_tready, coef_tready
  );

  modport slave (
    input  cmd_tvalid, cmd_tile, cmd_base, cmd_count, coef_tvalid, coef_tdata,
    output cmd_tready, coef_tready
  );

endinterface

// File: rtl/fir_coef_loader.sv
// rtl/fir_coef_loader.sv - sequences coefficient downloads into the FIR MAC tiles
// Purpose: accepts a load command plus a coefficient stream, drives the shared
//          coefficient-buffer write port and freezes the target tile while its
//          coefficient set is being rewritten.
// Ports:
//   iClk, iRst         clock, synchronous active-high reset
//   bus                command + coefficient stream (slave side)
//   iAbort             abort the load in progress
//   oCoefBuff_wren     one-hot write enable, bit = target tile
//   oCoefBuff_wraddr   write address shared by all tiles
//   oCoefBuff_wrdata   write data shared by all tiles
//   oTileFreeze        target tile held frozen from accept through DONE
//   oBusy              not idle
//   oDone              one-cycle pulse on successful completion
//   oErr, oErrCode     one-cycle error pulse; code holds its last value
module fir_coef_loader
  import fir_coef_loader_pkg::*;
#(
  parameter int NUM_TILES = 3,
  parameter int COEF_W    = COEF_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int MAX_TAPS  = 256,
  parameter int CNT_W     = 9
) (
  input  logic                 iClk,
  input  logic                 iRst,
  fir_coef_loader_if.slave     bus,
  input  logic                 iAbort,
  output logic [NUM_TILES-1:0] oCoefBuff_wren,
  output logic [ADDR_W-1:0]    oCoefBuff_wraddr,
  output logic [COEF_W-1:0]    oCoefBuff_wrdata,
  output logic [NUM_TILES-1:0] oTileFreeze,
  output logic                 oBusy,
  output logic                 oDone,
  output logic                 oErr,
  output logic [1:0]           oErrCode
);

  logic [1:0]           state_q, state_d;
  logic [ADDR_W-1:0]    base_q, base_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [CNT_W-1:0]     idx_q, idx_d;
  logic [NUM_TILES-1:0] freeze_q, freeze_d;
  logic [NUM_TILES-1:0] wren_q, wren_d;
  logic [ADDR_W-1:0]    wraddr_q, wraddr_d;
  logic [COEF_W-1:0]    wrdata_q, wrdata_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  err_code_t            code_q, code_d;

  logic cmd_fire;
  logic coef_fire;
  logic last_coef;
  logic tile_bad;
  logic count_bad;

  assign cmd_fire  = bus.cmd_tvalid && (state_q == ST_IDLE);
  assign coef_fire = bus.coef_tvalid && (state_q == ST_LOAD);
  assign last_coef = (idx_q == count_q - CNT_W'(1));
  assign tile_bad  = (int'(bus.cmd_tile) >= NUM_TILES);
  assign count_bad = (bus.cmd_count == '0) || (int'(bus.cmd_count) > MAX_TAPS);

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    count_d  = count_q;
    idx_d    = idx_q;
    freeze_d = freeze_q;
    wren_d   = '0;
    wraddr_d = wraddr_q;
    wrdata_d = wrdata_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    code_d   = code_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          if (tile_bad) begin
            err_d  = 1'b1;
            code_d = ERR_TILE;
          end else if (count_bad) begin
            err_d  = 1'b1;
            code_d = ERR_COUNT;
          end else begin
            state_d  = ST_LOAD;
            base_d   = bus.cmd_base;
            count_d  = bus.cmd_count;
            idx_d    = '0;
            freeze_d = NUM_TILES'(1) << bus.cmd_tile;
          end
        end
      end

      ST_LOAD: begin
        if (coef_fire) begin
          // The freeze vector is already the one-hot tile select.
          wren_d   = freeze_q;
          wraddr_d = base_q + ADDR_W'(idx_q);
          wrdata_d = bus.coef_tdata;
          idx_d    = idx_q + CNT_W'(1);
          if (last_coef) begin
            state_d = ST_DRAIN;
          end
        end
        // Abort wins over a simultaneous last accept; that word is still
        // written because the write stage above is left untouched.
        if (iAbort) begin
          state_d  = ST_IDLE;
          freeze_d = '0;
          err_d    = 1'b1;
          code_d   = ERR_ABORT;
        end
      end

      ST_DRAIN: begin
        if (iAbort) begin
          state_d  = ST_IDLE;
          freeze_d = '0;
          err_d    = 1'b1;
          code_d   = ERR_ABORT;
        end else begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        freeze_d = '0;
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q  <= ST_IDLE;
      base_q   <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      freeze_q <= '0;
      wren_q   <= '0;
      wraddr_q <= '0;
      wrdata_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      freeze_q <= freeze_d;
      wren_q   <= wren_d;
      wraddr_q <= wraddr_d;
      wrdata_q <= wrdata_d;
      done_q   <= done_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

  assign bus.cmd_tready  = (state_q == ST_IDLE);
  assign bus.coef_tready = (state_q == ST_LOAD);
  assign oCoefBuff_wren   = wren_q;
  assign oCoefBuff_wraddr = wraddr_q;
  assign oCoefBuff_wrdata = wrdata_q;
  assign oTileFreeze      = freeze_q;
  assign oBusy            = (state_q != ST_IDLE);
  assign oDone            = done_q;
  assign oErr             = err_q;
  assign oErrCode         = code_q;

endmodule

// File: tb/tb_fir_coef_loader.sv
// tb/tb_fir_coef_loader.sv - directed self-checking bench for fir_coef_loader
module tb_fir_coef_loader;
  import fir_coef_loader_pkg::*;

  logic        clk;
  logic        rst;
  logic        abort;
  logic [2:0]  wren;
  logic [31:0] wraddr;
  logic [17:0] wrdata;
  logic [2:0]  freeze;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  int checks;
  int failures;
  int wr_cnt;
  int done_cnt;

  fir_coef_loader_if #(.ADDR_W(32), .COEF_W(18), .CNT_W(9)) bus ();

  fir_coef_loader #(
    .NUM_TILES(3), .COEF_W(18), .ADDR_W(32), .MAX_TAPS(256), .CNT_W(9)
  ) dut (
    .iClk(clk),
    .iRst(rst),
    .bus(bus.slave),
    .iAbort(abort),
    .oCoefBuff_wren(wren),
    .oCoefBuff_wraddr(wraddr),
    .oCoefBuff_wrdata(wrdata),
    .oTileFreeze(freeze),
    .oBusy(busy),
    .oDone(done),
    .oErr(err),
    .oErrCode(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wren != 3'b000) wr_cnt = wr_cnt + 1;
    if (done) done_cnt = done_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] tile, input logic [31:0] base, input logic [8:0] count);
    bus.cmd_tvalid = 1'b1;
    bus.cmd_tile   = tile;
    bus.cmd_base   = base;
    bus.cmd_count  = count;
    step();
    bus.cmd_tvalid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s_done_timeout: got done=%0b expected 1", name, done);
    end
    step();
  endtask

  task automatic test_reset();
    checks++;
    if ({wren, wraddr, wrdata, freeze, busy, done, err, err_code} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got wren=%b addr=%h data=%h frz=%b busy=%b done=%b err=%b code=%0d expected all 0",
               wren, wraddr, wrdata, freeze, busy, done, err, err_code);
    end
    checks++;
    if (bus.cmd_tready !== 1'b1 || bus.coef_tready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready: got cmd_ready=%b coef_ready=%b expected 1/0", bus.cmd_tready, bus.coef_tready);
    end
  endtask

  task automatic test_back_to_back();
    send_cmd(8'd1, 32'h10, 9'd4);
    checks++;
    if (freeze !== 3'b010 || busy !== 1'b1 || bus.cmd_tready !== 1'b0 || bus.coef_tready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_accept: got frz=%b busy=%b cmd_ready=%b coef_ready=%b expected 010/1/0/1",
               freeze, busy, bus.cmd_tready, bus.coef_tready);
    end
    bus.coef_tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.coef_tdata = 18'(5 + i);
      step();
      checks++;
      if (wren !== 3'b010 || wraddr !== 32'(32'h10 + i) || wrdata !== 18'(5 + i) || freeze !== 3'b010) begin
        failures++;
        $display("FAIL b2b_write%0d: got wren=%b addr=%h data=%0d frz=%b expected 010/%h/%0d/010",
                 i, wren, wraddr, wrdata, freeze, 32'h10 + i, 5 + i);
      end
    end
    bus.coef_tvalid = 1'b0;
    checks++;
    if (bus.coef_tready !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain: got coef_ready=%b done=%b expected 0/0", bus.coef_tready, done);
    end
    step();
    checks++;
    if (done !== 1'b1 || freeze !== 3'b010 || wren !== 3'b000) begin
      failures++;
      $display("FAIL b2b_done: got done=%b frz=%b wren=%b expected 1/010/000", done, freeze, wren);
    end
    step();
    checks++;
    if (done !== 1'b0 || freeze !== 3'b000 || busy !== 1'b0 || bus.cmd_tready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_idle: got done=%b frz=%b busy=%b cmd_ready=%b expected 0/000/0/1",
               done, freeze, busy, bus.cmd_tready);
    end
  endtask

  task automatic test_gaps();
    int w0;
    w0 = wr_cnt;
    send_cmd(8'd1, 32'h10, 9'd4);
    for (int c = 0; c < 8; c++) begin
      bus.coef_tvalid = (c % 2 == 0);
      bus.coef_tdata  = 18'(5 + c / 2);
      step();
      checks++;
      if (c % 2 == 0) begin
        if (wren !== 3'b010 || wraddr !== 32'(32'h10 + c / 2) || wrdata !== 18'(5 + c / 2)) begin
          failures++;
          $display("FAIL gap_write%0d: got wren=%b addr=%h data=%0d expected 010/%h/%0d",
                   c, wren, wraddr, wrdata, 32'h10 + c / 2, 5 + c / 2);
        end
      end else if (wren !== 3'b000) begin
        failures++;
        $display("FAIL gap_stall%0d: got wren=%b expected 000", c, wren);
      end
    end
    bus.coef_tvalid = 1'b0;
    wait_done("gap");
    checks++;
    if (wr_cnt - w0 !== 4) begin
      failures++;
      $display("FAIL gap_write_count: got %0d expected 4", wr_cnt - w0);
    end
  endtask

  task automatic test_reject();
    logic [7:0] tiles [3];
    logic [8:0] counts [3];
    logic [1:0] codes [3];
    tiles  = '{8'd3, 8'd0, 8'd2};
    counts = '{9'd4, 9'd0, 9'd257};
    codes  = '{ERR_TILE, ERR_COUNT, ERR_COUNT};
    for (int k = 0; k < 3; k++) begin
      send_cmd(tiles[k], 32'h0, counts[k]);
      checks++;
      if (err !== 1'b1 || err_code !== codes[k] || freeze !== 3'b000 || wren !== 3'b000 ||
          busy !== 1'b0 || bus.cmd_tready !== 1'b1) begin
        failures++;
        $display("FAIL reject%0d: got err=%b code=%0d frz=%b wren=%b busy=%b cmd_ready=%b expected 1/%0d/000/000/0/1",
                 k, err, err_code, freeze, wren, busy, bus.cmd_tready, codes[k]);
      end
      step();
      checks++;
      if (err !== 1'b0 || err_code !== codes[k]) begin
        failures++;
        $display("FAIL reject%0d_hold: got err=%b code=%0d expected 0/%0d", k, err, err_code, codes[k]);
      end
    end
  endtask

  task automatic test_abort();
    int w0;
    w0 = wr_cnt;
    send_cmd(8'd2, 32'h40, 9'd8);
    bus.coef_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.coef_tdata = 18'(20 + i);
      step();
    end
    bus.coef_tvalid = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || err !== 1'b1 || err_code !== ERR_ABORT || freeze !== 3'b000 ||
        bus.cmd_tready !== 1'b1 || wren !== 3'b000) begin
      failures++;
      $display("FAIL abort_state: got busy=%b err=%b code=%0d frz=%b cmd_ready=%b wren=%b expected 0/1/3/000/1/000",
               busy, err, err_code, freeze, bus.cmd_tready, wren);
    end
    checks++;
    if (wr_cnt - w0 !== 3) begin
      failures++;
      $display("FAIL abort_write_count: got %0d expected 3", wr_cnt - w0);
    end
    send_cmd(8'd0, 32'h0, 9'd1);
    checks++;
    if (freeze !== 3'b001 || busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_followup: got frz=%b busy=%b expected 001/1", freeze, busy);
    end
    bus.coef_tvalid = 1'b1;
    bus.coef_tdata  = 18'h2AAAA;
    step();
    bus.coef_tvalid = 1'b0;
    checks++;
    if (wren !== 3'b001 || wraddr !== 32'h0 || wrdata !== 18'h2AAAA) begin
      failures++;
      $display("FAIL abort_followup_write: got wren=%b addr=%h data=%h expected 001/0/2aaaa", wren, wraddr, wrdata);
    end
    wait_done("abort_followup");
  endtask

  task automatic test_abort_last();
    int d0;
    send_cmd(8'd0, 32'h20, 9'd2);
    bus.coef_tvalid = 1'b1;
    bus.coef_tdata  = 18'd11;
    step();
    bus.coef_tdata  = 18'd12;
    abort = 1'b1;
    step();
    abort = 1'b0;
    bus.coef_tvalid = 1'b0;
    d0 = done_cnt;
    checks++;
    if (wren !== 3'b001 || wraddr !== 32'h21 || wrdata !== 18'd12 || busy !== 1'b0 ||
        err !== 1'b1 || err_code !== ERR_ABORT) begin
      failures++;
      $display("FAIL abort_last: got wren=%b addr=%h data=%0d busy=%b err=%b code=%0d expected 001/21/12/0/1/3",
               wren, wraddr, wrdata, busy, err, err_code);
    end
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (done_cnt !== d0) begin
      failures++;
      $display("FAIL abort_last_nodone: got %0d done pulses expected 0", done_cnt - d0);
    end
  endtask

  task automatic test_addr_wrap();
    logic [31:0] exp_addr [4];
    exp_addr = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    send_cmd(8'd0, 32'hFFFF_FFFE, 9'd4);
    bus.coef_tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.coef_tdata = 18'(100 + i);
      step();
      checks++;
      if (wren !== 3'b001 || wraddr !== exp_addr[i] || wrdata !== 18'(100 + i)) begin
        failures++;
        $display("FAIL wrap_write%0d: got wren=%b addr=%h data=%0d expected 001/%h/%0d",
                 i, wren, wraddr, wrdata, exp_addr[i], 100 + i);
      end
    end
    bus.coef_tvalid = 1'b0;
    wait_done("wrap");
  endtask

  task automatic test_reset_mid_load();
    send_cmd(8'd2, 32'h80, 9'd4);
    bus.coef_tvalid = 1'b1;
    bus.coef_tdata  = 18'd7;
    step();
    step();
    bus.coef_tvalid = 1'b0;
    send_cmd(8'd0, 32'h0, 9'd1);
    checks++;
    if (freeze !== 3'b100 || busy !== 1'b1 || bus.cmd_tready !== 1'b0 || bus.coef_tready !== 1'b1) begin
      failures++;
      $display("FAIL busy_cmd_ignored: got frz=%b busy=%b cmd_ready=%b coef_ready=%b expected 100/1/0/1",
               freeze, busy, bus.cmd_tready, bus.coef_tready);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({wren, wraddr, wrdata, freeze, busy, done, err, err_code} !== '0 ||
        bus.cmd_tready !== 1'b1 || bus.coef_tready !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_load: got wren=%b addr=%h data=%h frz=%b busy=%b done=%b err=%b code=%0d cmd_ready=%b coef_ready=%b expected zeros, cmd_ready=1",
               wren, wraddr, wrdata, freeze, busy, done, err, err_code, bus.cmd_tready, bus.coef_tready);
    end
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    rst             = 1'b1;
    abort           = 1'b0;
    bus.cmd_tvalid  = 1'b0;
    bus.cmd_tile    = '0;
    bus.cmd_base    = '0;
    bus.cmd_count   = '0;
    bus.coef_tvalid = 1'b0;
    bus.coef_tdata  = '0;
    step();
    step();
    rst = 1'b0;
    test_reset();
    test_back_to_back();
    test_gaps();
    test_reject();
    test_abort();
    test_abort_last();
    test_addr_wrap();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
